// File: rtl/synchro_filt.sv
// Multi-channel synchroniser with per-channel persistence filter and edge pulses.
// Each channel passes through a STAGES-deep flop chain, then a FILT_LEN-cycle deglitch counter.
module synchro_filt #(
  parameter int              CH       = 4,
  parameter int              STAGES   = 2,
  parameter int              FILT_LEN = 1,
  parameter logic [CH-1:0]   RST_VAL  = '0
) (
  input  logic          b_clk,
  input  logic          rst,
  input  logic [CH-1:0] async_in,
  output logic [CH-1:0] sync_out,
  output logic [CH-1:0] rise_pls,
  output logic [CH-1:0] fall_pls,
  output logic [CH-1:0] chg_pls
);

  localparam int               CNT_W   = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

  logic [CH-1:0]    stg [STAGES];
  logic [CH-1:0]    raw;
  logic [CH-1:0]    upd;
  logic [CNT_W-1:0] cnt     [CH];
  logic [CNT_W-1:0] cnt_nxt [CH];

  assign raw = stg[STAGES-1];

  // Pure flop chain: only stg[0] touches the asynchronous input.
  always_ff @(posedge b_clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) stg[k] <= RST_VAL;
    end else begin
      stg[0] <= async_in;
      for (int k = 1; k < STAGES; k++) stg[k] <= stg[k-1];
    end
  end

  always_comb begin
    upd = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_nxt[i] = '0;
      if (raw[i] != sync_out[i]) begin
        if (cnt[i] == CNT_MAX) upd[i] = 1'b1;
        else                   cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  // Accepted changes flip the level and fire the matching pulse in the same cycle.
  always_ff @(posedge b_clk) begin
    if (rst) begin
      sync_out <= RST_VAL;
      rise_pls <= '0;
      fall_pls <= '0;
      chg_pls  <= '0;
      for (int i = 0; i < CH; i++) cnt[i] <= '0;
    end else begin
      sync_out <= sync_out ^ upd;
      rise_pls <= upd & raw;
      fall_pls <= upd & ~raw;
      chg_pls  <= upd;
      for (int i = 0; i < CH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

endmodule
